// File: rtl/rs_issue_select.sv
// rtl/rs_issue_select.sv - round-robin RS issue selector for NUM_ALU ALUs, one MULT and one MEM unit.
// Grants are combinational; the per-class pointers and the MULT lockout counter are registered.
package rs_issue_select_pkg;
  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_MEM  = 2'd2,
    FU_NOP  = 2'd3
  } func_unit_t;
endpackage

module rs_issue_select
  import rs_issue_select_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_ALU     = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int MULT_II     = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [WIDTH-1:0]           req_i,
  input  func_unit_t [WIDTH-1:0]     func_in_i,
  input  logic [NUM_ALU-1:0]         alu_stall_i,
  input  logic                       mem_stall_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           gnt_o,
  output logic [NUM_ALU*WIDTH-1:0]   alu_gnt_bus_o,
  output logic [WIDTH-1:0]           mult_gnt_o,
  output logic [WIDTH-1:0]           mem_gnt_o,
  output logic                       mult_busy_o
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (MULT_II > 1) ? $clog2(MULT_II + 1) : 1;
  localparam logic [PW:0]   WIDTH_C = (PW + 1)'(WIDTH);
  localparam logic [PW-1:0] LAST_C  = PW'(WIDTH - 1);

  logic [PW-1:0] alu_ptr_q, alu_ptr_d;
  logic [PW-1:0] mult_ptr_q, mult_ptr_d;
  logic [PW-1:0] mem_ptr_q, mem_ptr_d;
  logic [CW-1:0] mult_cnt_q, mult_cnt_d;

  logic [WIDTH-1:0] alu_cand, mult_cand, mem_cand, alu_taken;
  logic [NUM_ALU-1:0][WIDTH-1:0] alu_gnt;
  logic             active, found;
  logic [PW-1:0]    idx;
  int               n_acc;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] ptr, input int j);
    logic [PW:0] s;
    s = {1'b0, ptr} + (PW + 1)'(j);
    if (s >= WIDTH_C) s = s - WIDTH_C;
    return s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (i == LAST_C) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      alu_cand[i]  = req_i[i] && (func_in_i[i] == FU_ALU);
      mult_cand[i] = req_i[i] && (func_in_i[i] == FU_MULT);
      mem_cand[i]  = req_i[i] && (func_in_i[i] == FU_MEM);
    end
  end

  // Acceptance order MULT, MEM, ALU0..ALUn-1 implements the issue cap.
  always_comb begin
    mult_gnt_o = '0;
    mem_gnt_o  = '0;
    alu_gnt    = '0;
    alu_taken  = '0;
    alu_ptr_d  = alu_ptr_q;
    mult_ptr_d = mult_ptr_q;
    mem_ptr_d  = mem_ptr_q;
    n_acc      = 0;
    found      = 1'b0;
    idx        = '0;
    active     = !reset_i && !flush_i;

    if (active && (mult_cnt_q == '0)) begin
      for (int j = 0; j < WIDTH; j++) begin
        idx = wrap_idx(mult_ptr_q, j);
        if (!found && mult_cand[idx] && (n_acc < ISSUE_WIDTH)) begin
          found           = 1'b1;
          mult_gnt_o[idx] = 1'b1;
          mult_ptr_d      = next_ptr(idx);
          n_acc           = n_acc + 1;
        end
      end
    end

    found = 1'b0;
    if (active && !mem_stall_i) begin
      for (int j = 0; j < WIDTH; j++) begin
        idx = wrap_idx(mem_ptr_q, j);
        if (!found && mem_cand[idx] && (n_acc < ISSUE_WIDTH)) begin
          found          = 1'b1;
          mem_gnt_o[idx] = 1'b1;
          mem_ptr_d      = next_ptr(idx);
          n_acc          = n_acc + 1;
        end
      end
    end

    // Later free ALUs take later candidates, so the last write leaves the pointer past the last grant.
    for (int k = 0; k < NUM_ALU; k++) begin
      found = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        idx = wrap_idx(alu_ptr_q, j);
        if (active && !alu_stall_i[k] && !found && (n_acc < ISSUE_WIDTH) &&
            alu_cand[idx] && !alu_taken[idx]) begin
          found           = 1'b1;
          alu_taken[idx]  = 1'b1;
          alu_gnt[k][idx] = 1'b1;
          alu_ptr_d       = next_ptr(idx);
        end
      end
      if (found) n_acc = n_acc + 1;
    end

    if (flush_i) begin
      mult_cnt_d = '0;
    end else if (|mult_gnt_o) begin
      mult_cnt_d = CW'(MULT_II - 1);
    end else if (mult_cnt_q != '0) begin
      mult_cnt_d = mult_cnt_q - 1'b1;
    end else begin
      mult_cnt_d = mult_cnt_q;
    end
  end

  always_comb begin
    gnt_o = mult_gnt_o | mem_gnt_o;
    for (int k = 0; k < NUM_ALU; k++) gnt_o = gnt_o | alu_gnt[k];
  end

  assign alu_gnt_bus_o = alu_gnt;
  assign mult_busy_o   = (mult_cnt_q != '0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      alu_ptr_q  <= '0;
      mult_ptr_q <= '0;
      mem_ptr_q  <= '0;
      mult_cnt_q <= '0;
    end else begin
      alu_ptr_q  <= alu_ptr_d;
      mult_ptr_q <= mult_ptr_d;
      mem_ptr_q  <= mem_ptr_d;
      mult_cnt_q <= mult_cnt_d;
    end
  end

  a_cap:  assert property (@(posedge clock_i) $countones(gnt_o) <= ISSUE_WIDTH);
  a_mult: assert property (@(posedge clock_i) $onehot0(mult_gnt_o));
  a_mem:  assert property (@(posedge clock_i) $onehot0(mem_gnt_o));
  for (genvar g = 0; g < NUM_ALU; g++) begin : g_alu_chk
    a_alu: assert property (@(posedge clock_i) $onehot0(alu_gnt[g]));
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// tb/tb_rs_issue_select.sv - directed self-checking bench for rs_issue_select.
// Default parameters: WIDTH=16, NUM_ALU=2, ISSUE_WIDTH=2, MULT_II=4.
module tb_rs_issue_select;
  import rs_issue_select_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       req;
  func_unit_t [15:0] func;
  logic [1:0]        alu_stall;
  logic              mem_stall;
  logic              flush;
  logic [15:0]       gnt, mult_gnt, mem_gnt;
  logic [31:0]       alu_bus;
  logic              mult_busy;

  int total = 0;
  int bad   = 0;

  rs_issue_select #(
    .WIDTH(16), .NUM_ALU(2), .ISSUE_WIDTH(2), .MULT_II(4)
  ) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .req_i        (req),
    .func_in_i    (func),
    .alu_stall_i  (alu_stall),
    .mem_stall_i  (mem_stall),
    .flush_i      (flush),
    .gnt_o        (gnt),
    .alu_gnt_bus_o(alu_bus),
    .mult_gnt_o   (mult_gnt),
    .mem_gnt_o    (mem_gnt),
    .mult_busy_o  (mult_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req       = '0;
    alu_stall = '0;
    mem_stall = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < 16; i++) func[i] = FU_NOP;
  endtask

  task automatic put(input int i, input func_unit_t f);
    req[i]  = 1'b1;
    func[i] = f;
  endtask

  // Check this cycle's outputs, then advance one clock edge.
  task automatic step(input string tag, input logic [15:0] e_gnt, input logic [31:0] e_bus,
                      input logic [15:0] e_mult, input logic [15:0] e_mem, input logic e_busy);
    #1;
    chk({tag, ".gnt"},  {16'h0, gnt},      {16'h0, e_gnt});
    chk({tag, ".alu"},  alu_bus,           e_bus);
    chk({tag, ".mult"}, {16'h0, mult_gnt}, {16'h0, e_mult});
    chk({tag, ".mem"},  {16'h0, mem_gnt},  {16'h0, e_mem});
    chk({tag, ".busy"}, {31'h0, mult_busy}, {31'h0, e_busy});
    chk({tag, ".or"},   {16'h0, gnt},
        {16'h0, mult_gnt | mem_gnt | alu_bus[15:0] | alu_bus[31:16]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    put(0, FU_ALU); put(15, FU_ALU);
    @(posedge clk); #1;
    step("reset", 16'h0, 32'h0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;

    for (int c = 0; c < 3; c++) step("wrap_rr", 16'h8001, 32'h8000_0001, 16'h0, 16'h0, 1'b0);

    clr(); put(3, FU_ALU);
    step("ptr_to4", 16'h0008, 32'h0000_0008, 16'h0, 16'h0, 1'b0);
    clr(); put(3, FU_ALU); put(5, FU_ALU); put(9, FU_ALU); alu_stall = 2'b01;
    step("stall01", 16'h0020, 32'h0020_0000, 16'h0, 16'h0, 1'b0);
    alu_stall = 2'b00;
    step("ptr_at6", 16'h0208, 32'h0008_0200, 16'h0, 16'h0, 1'b0);

    clr(); put(1, FU_MULT); put(4, FU_MEM); put(6, FU_ALU); put(8, FU_ALU);
    step("cap", 16'h0012, 32'h0, 16'h0002, 16'h0010, 1'b0);
    clr(); put(3, FU_ALU); put(5, FU_ALU);
    step("cap_ptr_hold", 16'h0028, 32'h0008_0020, 16'h0, 16'h0, 1'b1);

    clr(); mem_stall = 1'b1; put(0, FU_MEM); put(1, FU_NOP);
    step("mem_stall", 16'h0, 32'h0, 16'h0, 16'h0, 1'b1);
    clr(); put(0, FU_MEM); put(6, FU_MEM);
    step("mem_ptr_hold", 16'h0040, 32'h0, 16'h0, 16'h0040, 1'b1);
    clr();
    step("empty", 16'h0, 32'h0, 16'h0, 16'h0, 1'b0);

    clr(); alu_stall = 2'b11; put(3, FU_ALU); put(8, FU_MEM); put(10, FU_MULT);
    step("all_stall", 16'h0500, 32'h0, 16'h0400, 16'h0100, 1'b0);
    clr();
    for (int c = 0; c < 3; c++) step("drain", 16'h0, 32'h0, 16'h0, 16'h0, 1'b1);

    clr(); put(2, FU_MULT); put(7, FU_MULT);
    step("mult_t", 16'h0004, 32'h0, 16'h0004, 16'h0, 1'b0);
    clr(); put(7, FU_MULT);
    for (int c = 1; c <= 3; c++) step("mult_lock", 16'h0, 32'h0, 16'h0, 16'h0, 1'b1);
    step("mult_t4", 16'h0080, 32'h0, 16'h0080, 16'h0, 1'b0);
    clr(); put(9, FU_MULT); put(3, FU_ALU);
    step("mult_busy3", 16'h0008, 32'h0000_0008, 16'h0, 16'h0, 1'b1);

    clr(); flush = 1'b1;
    put(7, FU_MULT); put(9, FU_MULT); put(3, FU_ALU); put(5, FU_ALU); put(8, FU_MEM);
    step("flush", 16'h0, 32'h0, 16'h0, 16'h0, 1'b1);
    clr(); put(7, FU_MULT); put(9, FU_MULT);
    step("post_flush", 16'h0200, 32'h0, 16'h0200, 16'h0, 1'b0);

    clr(); reset = 1'b1; put(7, FU_MULT); put(3, FU_ALU);
    step("reset_mid", 16'h0, 32'h0, 16'h0, 16'h0, 1'b1);
    reset = 1'b0;
    clr(); put(7, FU_MULT); put(9, FU_MULT); put(3, FU_ALU); put(5, FU_ALU);
    step("post_reset", 16'h0088, 32'h0000_0008, 16'h0080, 16'h0, 1'b0);

    clr(); put(14, FU_ALU);
    step("ptr_to15", 16'h4000, 32'h0000_4000, 16'h0, 16'h0, 1'b1);
    clr(); put(15, FU_ALU);
    step("grant15", 16'h8000, 32'h0000_8000, 16'h0, 16'h0, 1'b1);
    clr(); put(1, FU_ALU); put(15, FU_ALU);
    step("ptr_wrap0", 16'h8002, 32'h8000_0002, 16'h0, 16'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Parametrised issue selector between the reservation station and the functional units.
- Each cycle it picks which ready RS entries are granted to NUM_ALU ALUs, one MULT and one MEM unit.
- Selection is round-robin per FU class, with a total cap of ISSUE_WIDTH grants per cycle.
- It adds what the two-stage fixed-priority selector lacks: per-ALU stall masking for any ALU count, fairness pointers, and a MULT initiation-interval lockout.

Parameters:
- WIDTH, 16: number of RS entries; need not be a power of 2.
- NUM_ALU, 2: number of ALU units, 1..4.
- ISSUE_WIDTH, 2: maximum total grants per cycle, 1..NUM_ALU+2.
- MULT_II, 4: cycles between successive MULT grants; 1 means fully pipelined.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  WIDTH  ready bit per RS entry.
- func_in  in  FUNC_UNIT[WIDTH]  FU class per entry (ALU/MULT/MEM/NOP).
- alu_stall  in  NUM_ALU  ALU k cannot accept this cycle.
- mem_stall  in  1  MEM cannot accept this cycle.
- flush  in  1  squash; suppresses grants this cycle.
- gnt  out  WIDTH  OR of all unit grants; the RS clears these entries.
- alu_gnt_bus  out  NUM_ALU*WIDTH  one-hot (or zero) grant for ALU k in slice [k*WIDTH +: WIDTH].
- mult_gnt  out  WIDTH  one-hot or zero.
- mem_gnt  out  WIDTH  one-hot or zero.
- mult_busy  out  1  MULT lockout counter nonzero.

Behaviour:
- Grant outputs are combinational from req, func_in, stalls, flush and the registered state. Zero latency: a grant is seen in the same cycle as req.
- State registers:
  - alu_ptr, mult_ptr, mem_ptr: each $clog2(WIDTH) bits.
  - mult_cnt: $clog2(MULT_II+1) bits.
- Reset: all pointers 0, mult_cnt 0, mult_busy 0.
- All grant outputs are 0 whenever reset or flush is high.
- Candidate sets:
  - An entry is an X-candidate iff req[i]=1 and func_in[i]=X. NOP entries are never granted.
  - Search order for class X is ptr_X, ptr_X+1, …, WIDTH-1, 0, …, ptr_X-1 (modulo WIDTH).
- MULT:
  - Eligible iff mult_cnt==0.
  - Takes the first MULT-candidate in search order.
- MEM:
  - Eligible iff mem_stall==0.
  - Takes the first MEM-candidate in search order.
- ALU:
  - Non-stalled ALUs, taken in ascending index k, receive successive ALU-candidates in search order.
  - The first free ALU gets the first candidate, the next free ALU gets the second, and so on.
  - Stalled ALUs get zero grants. Example: alu_stall=01 means ALU1 gets the first candidate.
- Issue cap:
  - Tentative grants are accepted in fixed order: MULT, MEM, then ALUs by ascending k.
  - Acceptance stops when ISSUE_WIDTH grants are reached; grants beyond the cap are dropped (zero).
- No entry is ever granted to two units; the class partition guarantees this.
- Pointer update, on a clock edge with reset=0 and flush=0:
  - If class X issued at least one accepted grant, ptr_X <= (index of last accepted X grant in search order + 1) mod WIDTH.
  - Otherwise ptr_X holds its value.
- mult_cnt update, in priority order:
  - reset or flush: mult_cnt <= 0.
  - Else an accepted MULT grant: mult_cnt <= MULT_II-1.
  - Else if mult_cnt>0: mult_cnt <= mult_cnt-1.
- With MULT_II=1, mult_cnt stays 0, so back-to-back MULT grants are allowed.
- mult_busy = (mult_cnt != 0).
- Boundary conditions:
  - Pointer at WIDTH-1 with the granted index WIDTH-1: the pointer wraps to 0.
  - All ALUs stalled: no ALU grants. MULT/MEM are still granted up to the cap.
  - Empty req: all grants 0 and the pointers hold.
  - Reset asserted mid-lockout clears mult_cnt on the next edge; grants are 0 during reset.
  - Flush while a req is present: no grant. Pointers hold, mult_cnt is cleared.
- Invariants (checked by assertion):
  - popcount(gnt) <= ISSUE_WIDTH.
  - Each unit grant is one-hot or zero.
  - gnt equals the OR of all unit grants.

Test Plan:
1. Round-robin wrap.
   - Stimulus: WIDTH=16, NUM_ALU=2, ISSUE_WIDTH=2, after reset. Hold req=0x8001 with both entries ALU for 3 cycles.
   - Required: cycle 0 grants entries 0→ALU0 and 15→ALU1; alu_ptr becomes 0. Both entries are granted again each cycle with the same mapping.
2. Stall masking.
   - Stimulus: req bits 3,5,9 all ALU, alu_ptr=4, alu_stall=2'b01.
   - Required: ALU1 gets entry 5, ALU0 gets 0, gnt=0x0020, and alu_ptr becomes 6.
3. MULT lockout.
   - Stimulus: MULT_II=4, MULT entry 2 requesting, grant taken at cycle t, and MULT entry 7 continuously requesting.
   - Required: mult_gnt=0 and mult_busy=1 for cycles t+1..t+3. Entry 7 is granted at t+4.
4. Issue cap priority.
   - Stimulus: ISSUE_WIDTH=2, with req on MULT entry 1, MEM entry 4, ALU entries 6 and 8, and no stalls.
   - Required: mult_gnt=entry 1, mem_gnt=entry 4, alu_gnt_bus=0. alu_ptr holds.
5. Flush and reset mid-operation.
   - Stimulus: flush asserted with mult_cnt=2 and req present.
   - Required: all grants are 0, mult_cnt becomes 0 next cycle, and the pointers are unchanged. Reset asserted at any point gives zero grants and all state at 0 on the next edge.
6. MEM stall with NOP.
   - Stimulus: mem_stall=1, with MEM entry 0 and NOP entry 1 requesting.
   - Required: gnt=0, and mem_ptr is unchanged.
